// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic number generator front end:
// FSM state encoding, maximal-length LFSR tap table and a width-aware rotate.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sc_state_t;

  // Fibonacci feedback masks, bit i set means register bit i feeds the XOR.
  // Every entry gives a maximal-length sequence (period 2^w-1) for a
  // shift-left register that inserts the feedback bit at bit 0.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Left rotation by k of the low w bits of x; bits above w come back as 0.
  function automatic logic [15:0] rotl(input logic [15:0] x, input int k, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) r[i] = x[(i - (k % w) + w) % w];
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci maximal-length LFSR with synchronous load. A zero seed would lock
// the register, so it is replaced by 1 on load.
module sc_lfsr
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Reset to 1, load the (non-zero) seed, or advance one step when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ONE;
    end else if (load) begin
      state <= (seed == '0) ? ONE : seed;
    end else if (en) begin
      state <= {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/sc_sng_frame.sv
// Stochastic-computing frame generator: drives CHANNELS decorrelated
// bitstreams (plus one-cycle-delayed copies) into an external combinational
// SC core and counts the core's output over one full LFSR period.
//
// Handshake: start is a single-cycle request. It is accepted on any clock
// edge where the FSM is in IDLE or DONE and rst is low; seed and value are
// captured on that same edge. While busy, start, seed and value are ignored.
// done pulses for one cycle when count holds the final frame result.
module sc_sng_frame
  import sc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          seed,
  input  logic [CHANNELS*WIDTH-1:0] value,
  input  logic                      sc_in,
  output logic [CHANNELS-1:0]       x_bits,
  output logic [CHANNELS-1:0]       x_bits_d,
  output logic                      x_valid,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH-1:0]          count,
  output logic [WIDTH-1:0]          lfsr_state
);

  localparam int               N_CYC    = (1 << WIDTH) - 1;
  localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(N_CYC - 1);
  localparam logic [WIDTH-1:0] TAPS     = WIDTH'(lfsr_taps(WIDTH));

  sc_state_t                 state;
  logic [WIDTH-1:0]          cyc;
  logic [CHANNELS*WIDTH-1:0] value_q;
  logic                      accept;
  logic [WIDTH-1:0]          seed_eff;
  logic [WIDTH-1:0]          lfsr_nxt;
  logic [WIDTH-1:0]          cmp_word;
  logic [CHANNELS*WIDTH-1:0] cmp_val;
  logic [CHANNELS-1:0]       x_next;

  sc_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (seed),
    .en    (state == ST_RUN),
    .state (lfsr_state)
  );

  // The registered streams always show the comparison of the word the LFSR
  // is about to hold: on the accepting edge that is the seed itself, during
  // RUN it is the next LFSR step. So lfsr_state matches the word behind x_bits.
  always_comb begin
    accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    seed_eff = (seed == '0) ? WIDTH'(1) : seed;
    lfsr_nxt = {lfsr_state[WIDTH-2:0], ^(lfsr_state & TAPS)};
    cmp_word = accept ? seed_eff : lfsr_nxt;
    cmp_val  = accept ? value : value_q;
  end

  // One comparator per channel; rotating the shared word decorrelates streams.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_cmp
    logic [15:0] rot16;
    always_comb begin
      rot16     = rotl(16'(cmp_word), k, WIDTH);
      x_next[k] = rot16[WIDTH-1:0] < cmp_val[k*WIDTH +: WIDTH];
    end
  end

  // Frame FSM with registered stream, status and counter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      value_q  <= '0;
      x_bits   <= '0;
      x_bits_d <= '0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          count    <= count + WIDTH'(sc_in);
          x_bits_d <= x_bits;
          cyc      <= cyc + 1'b1;
          if (cyc == LAST_CYC) begin
            state   <= ST_DONE;
            x_bits  <= '0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            x_bits <= x_next;
          end
        end
        default: begin
          // IDLE and DONE behave alike: wait for start, DONE falls to IDLE.
          done <= 1'b0;
          if (accept) begin
            state    <= ST_RUN;
            value_q  <= value;
            count    <= '0;
            cyc      <= '0;
            x_bits   <= x_next;
            x_bits_d <= '0;
            x_valid  <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state    <= ST_IDLE;
            x_bits   <= '0;
            x_bits_d <= x_bits;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_sng_frame.sv
// Self-checking bench for sc_sng_frame (WIDTH=8, CHANNELS=2).
module tb_sc_sng_frame;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int N_CYC    = 255;

  // clock / reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                      start;
  logic [WIDTH-1:0]          seed;
  logic [CHANNELS*WIDTH-1:0] value;
  logic                      sc_in;
  logic                      sc_sel;
  logic [CHANNELS-1:0]       x_bits;
  logic [CHANNELS-1:0]       x_bits_d;
  logic                      x_valid;
  logic                      busy;
  logic                      done;
  logic [WIDTH-1:0]          count;
  logic [WIDTH-1:0]          lfsr_state;

  // External "SC core": a wire to one of the streams.
  assign sc_in = x_bits[sc_sel];

  sc_sng_frame #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .value      (value),
    .sc_in      (sc_in),
    .x_bits     (x_bits),
    .x_bits_d   (x_bits_d),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .lfsr_state (lfsr_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: expected count per frame, and expected per-channel ones {ch1,ch0}
  logic [WIDTH-1:0]   exp_q[$];
  logic [2*WIDTH-1:0] exp_ones_q[$];
  logic [WIDTH-1:0]   last_exp;

  // Every nonzero word appears once per frame, so ones = max(v-1, 0).
  function automatic logic [WIDTH-1:0] ones_model(input logic [WIDTH-1:0] v);
    return (v == 0) ? '0 : v - 1'b1;
  endfunction

  // driver: request a frame; called just before a rising edge
  task automatic kick(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] v0,
                      input logic [WIDTH-1:0] v1, input logic sel);
    seed   = s;
    value  = {v1, v0};
    sc_sel = sel;
    start  = 1'b1;
    exp_q.push_back(ones_model(sel ? v1 : v0));
    exp_ones_q.push_back({ones_model(v1), ones_model(v0)});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Follow one frame from its first valid cycle to the done cycle; returns
  // at the negedge of the done cycle.
  task automatic monitor_frame(input string name, input bit mid_pulse,
                               input logic [WIDTH-1:0] exp_lfsr_end);
    int done_at, vcnt, bcnt, bad_d, zero_l, o0, o1;
    logic [CHANNELS-1:0] prev_x;
    logic [WIDTH-1:0]    exp_c;
    logic [2*WIDTH-1:0]  exp_o;
    done_at = 0; vcnt = 0; bcnt = 0; bad_d = 0; zero_l = 0; o0 = 0; o1 = 0;
    prev_x = '0;
    for (int n = 1; n <= 400 && done_at == 0; n++) begin
      @(negedge clk);
      start = mid_pulse && (n == 50);
      if (mid_pulse && n == 50) begin
        value = ~value;
        seed  = ~seed;
      end
      if (n == 1) begin
        checks++;
        if (count !== 0 || x_valid !== 1'b1 || x_bits_d !== 0) begin
          errors++;
          $display("FAIL %s first_cycle: count=%0d x_valid=%b x_bits_d=%b, required 0/1/00",
                   name, count, x_valid, x_bits_d);
        end
      end
      if (x_valid === 1'b1) begin
        vcnt++;
        o0 += int'(x_bits[0]);
        o1 += int'(x_bits[1]);
        if (n > 1 && x_bits_d !== prev_x) bad_d++;
      end
      if (busy === 1'b1) bcnt++;
      if (lfsr_state === 0) zero_l++;
      prev_x = x_bits;
      if (done === 1'b1) done_at = n;
    end
    start = 1'b0;

    checks++;
    if (done_at != N_CYC + 1) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles, required %0d (0 = timeout)", name, done_at, N_CYC + 1);
    end
    checks++;
    if (vcnt != N_CYC || bcnt != N_CYC) begin
      errors++;
      $display("FAIL %s valid_len: x_valid %0d busy %0d cycles, required %0d", name, vcnt, bcnt, N_CYC);
    end
    checks++;
    if (bad_d != 0) begin
      errors++;
      $display("FAIL %s x_bits_d: %0d cycles differ from delayed x_bits, required 0", name, bad_d);
    end
    checks++;
    if (zero_l != 0) begin
      errors++;
      $display("FAIL %s lfsr_zero: lfsr read 0 in %0d cycles, required 0", name, zero_l);
    end
    checks++;
    if (lfsr_state !== exp_lfsr_end) begin
      errors++;
      $display("FAIL %s lfsr_period: lfsr=%0h at done, required %0h", name, lfsr_state, exp_lfsr_end);
    end
    checks++;
    if (exp_q.size() == 0 || exp_ones_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: no expected entry, required one", name);
    end else begin
      exp_c    = exp_q.pop_front();
      exp_o    = exp_ones_q.pop_front();
      last_exp = exp_c;
      if (count !== exp_c) begin
        errors++;
        $display("FAIL %s count: got %0d, required %0d", name, count, exp_c);
      end
      checks++;
      if (o0 != int'(exp_o[WIDTH-1:0]) || o1 != int'(exp_o[2*WIDTH-1:WIDTH])) begin
        errors++;
        $display("FAIL %s stream_ones: ch0 %0d ch1 %0d, required %0d %0d",
                 name, o0, o1, exp_o[WIDTH-1:0], exp_o[2*WIDTH-1:WIDTH]);
      end
    end
  endtask

  // After a frame: result held, streams quiet, no further done.
  task automatic after_frame_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (count !== last_exp || x_bits !== 0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s idle_hold: %0d bad cycles (count=%0d x_bits=%b x_valid=%b busy=%b done=%b), required count=%0d and quiet",
               name, bad, count, x_bits, x_valid, busy, done, last_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed = '0; value = '0; sc_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (x_bits !== 0 || x_bits_d !== 0 || x_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || count !== 0 || lfsr_state !== 8'd1) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: x_bits=%b x_bits_d=%b x_valid=%b busy=%b done=%b count=%0d lfsr=%0h, required zeros and lfsr=1",
                 i, x_bits, x_bits_d, x_valid, busy, done, count, lfsr_state);
      end
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    kick(8'd1, 8'd128, 8'($urandom_range(0, 255)), 1'b0);
    monitor_frame("basic_128", 1'b0, 8'd1);
    after_frame_check("basic_128");
  endtask

  task automatic test_extremes();
    logic [WIDTH-1:0] seeds [2];
    logic [WIDTH-1:0] vals [2];
    seeds[0] = 8'd1; seeds[1] = 8'd0;
    vals[0]  = 8'd0; vals[1]  = 8'd255;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 2; v++) begin
        @(negedge clk);
        kick(seeds[s], vals[v], 8'($urandom_range(0, 255)), 1'b0);
        monitor_frame($sformatf("extreme_s%0d_v%0d", seeds[s], vals[v]), 1'b0, 8'd1);
        after_frame_check("extreme");
      end
    end
  endtask

  task automatic test_two_channel();
    @(negedge clk);
    kick(8'h5A, 8'd200, 8'd100, 1'b1);
    monitor_frame("two_channel", 1'b0, 8'h5A);
    after_frame_check("two_channel");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] s;
    for (int i = 0; i < 3; i++) begin
      s = 8'($urandom_range(1, 255));
      @(negedge clk);
      kick(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      monitor_frame($sformatf("random_%0d", i), 1'b0, s);
      after_frame_check("random");
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    kick(8'd37, 8'd77, 8'($urandom_range(0, 255)), 1'b0);
    monitor_frame("b2b_first_midstart", 1'b1, 8'd37);
    // still in the done cycle: request the next frame right away
    kick(8'hA5, 8'd10, 8'd250, 1'b1);
    monitor_frame("b2b_second", 1'b0, 8'hA5);
    after_frame_check("b2b_second");
  endtask

  task automatic test_rst_mid();
    int dones;
    @(negedge clk);
    kick(8'd3, 8'd128, 8'd60, 1'b0);
    repeat (100) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    exp_q.delete();
    exp_ones_q.delete();
    @(negedge clk);
    checks++;
    if (x_bits !== 0 || x_bits_d !== 0 || x_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || count !== 0 || lfsr_state !== 8'd1) begin
      errors++;
      $display("FAIL rst_mid_state: x_bits=%b x_bits_d=%b x_valid=%b busy=%b done=%b count=%0d lfsr=%0h, required zeros and lfsr=1",
               x_bits, x_bits_d, x_valid, busy, done, count, lfsr_state);
    end
    dones = 0;
    for (int i = 0; i < 280; i++) begin
      @(negedge clk);
      if (done === 1'b1 || x_valid === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset, required 0", dones);
    end
    kick(8'd3, 8'd128, 8'd60, 1'b0);
    monitor_frame("after_rst", 1'b0, 8'd3);
    after_frame_check("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_two_channel();
    test_random();
    test_back_to_back();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sc_sng_frame.md
# sc_sng_frame

Parametrised stochastic-computing front end. It replaces the external state-feedback loop of the previous generation (the state word fed back cycle-by-cycle outside the circuit) with an internal maximal-length LFSR. It drives CHANNELS decorrelated stochastic bitstreams plus their one-cycle-delayed copies into a combinational SC core, and counts that core's output bit over one full LFSR period. One `start` yields one frame and one binary result.

## Interface
- WIDTH, 8: LFSR, comparator and result width; legal range 4..16.
- CHANNELS, 2: number of stochastic input streams; legal range 1..8.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  frame request; sampled only in IDLE or DONE
- seed  in  WIDTH  LFSR seed, latched on accepted start; value 0 is replaced by 1
- value  in  CHANNELS*WIDTH  binary probability per channel, channel k at [k*WIDTH +: WIDTH]; latched on accepted start
- sc_in  in  1  output bit of the external SC core, counted when x_valid=1
- x_bits  out  CHANNELS  registered stochastic streams
- x_bits_d  out  CHANNELS  x_bits delayed by one cycle
- x_valid  out  1  high on every frame cycle
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of frame
- count  out  WIDTH  number of sc_in ones in the last frame; held until next accepted start
- lfsr_state  out  WIDTH  current LFSR word (debug)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, latch seed and value, clear the ones counter, clear the cycle counter and x_bits_d, then go to RUN.
- RUN, every cycle:
  - x_bits[k] <= (rotl(lfsr, k) < value[k]), unsigned compare.
  - x_bits_d <= x_bits.
  - LFSR advances one step.
  - The cycle counter increments.
- RUN ends after exactly 2^WIDTH−1 valid cycles, then the FSM goes to DONE.
- LFSR:
  - Fibonacci, maximal length; taps come from the package table indexed by WIDTH.
  - Visits every nonzero word exactly once per frame, so it never locks at 0.
- rotl(lfsr, k) is a left rotation by k bits. It is a bijection on nonzero words, so per-channel ones count per frame is exactly max(value[k]−1, 0).
- Counter: count += sc_in on each cycle with x_valid=1. Width WIDTH suffices, maximum 2^WIDTH−1, no overflow possible.
- DONE lasts one cycle with done=1, then returns to IDLE. A start in the DONE cycle is accepted, which gives back-to-back frames.
- start while in RUN is ignored. value and seed changes while in RUN have no effect.

## Timing
- Reset values: state IDLE, x_bits=0, x_bits_d=0, x_valid=0, busy=0, done=0, count=0, lfsr_state=1.
- Start accepted at edge t:
  - x_valid=1 and busy=1 for cycles t+1 .. t+2^WIDTH−1.
  - The first x_bits are computed from the seed word.
- done=1 in cycle t+2^WIDTH. count is final in that same cycle and stays stable afterwards.
- sc_in is combinational from x_bits and is sampled in the same cycle as the x_bits that produced it.
- x_bits_d=0 in the first valid cycle of every frame.
- Between frames (IDLE): x_bits is held at 0 and the LFSR holds.
- rst mid-frame: next cycle all outputs are at reset values; any partial count is discarded.
- rst and start in the same cycle: rst wins, start is dropped.

## Structure
- Package sc_pkg:
  - FSM state enum.
  - Maximal-length tap table or function for WIDTH 4..16.
  - rotl function.
- Sub-module sc_lfsr: parameter WIDTH; ports clk, rst, load, seed, en, state. Handles the seed-zero substitution.
- Top module: FSM, comparators generated per channel, delay register, cycle counter, ones counter.

## Test plan
- Reset, then idle for 10 cycles -> all outputs at reset values, lfsr_state=1, no done.
- WIDTH=8, seed=1, value0=128, sc_in tied to x_bits[0], one start -> done exactly 256 cycles after start, count=127, x_valid high for exactly 255 cycles.
- value0=0 and value0=255 with sc_in=x_bits[0] -> count=0 and count=254 respectively. Repeat with seed=0 -> identical counts, LFSR never reads 0.
- CHANNELS=2, value=(200,100), sc_in=x_bits[1] -> count=99. Check that x_bits_d equals x_bits one cycle late and is 0 on the first valid cycle.
- start pulsed mid-RUN, and a new start in the DONE cycle -> mid-RUN start ignored (frame length unchanged); back-to-back frame begins the next cycle with count cleared.
- rst asserted at cycle 100 of a frame, together with start -> all outputs at reset values next cycle, no done, the following start produces a full correct frame.
